// File: rtl/lu_sequencer_if.sv
// Bundle between lu_sequencer, its upstream producer, the logical_unit
// datapath and the weight ROM. The sequencer takes the slave view.
interface lu_sequencer_if #(
  parameter int WORD_SIZE  = 16,
  parameter int ADDR_WIDTH = 4
);
  logic [WORD_SIZE-1:0]  data_i;
  logic                  valid_i;
  logic                  ready_o;
  logic [ADDR_WIDTH-1:0] addr_o;
  logic [WORD_SIZE-1:0]  lu_data_o;
  logic                  lu_reset_o;
  logic                  add_bias_o;
  logic                  sum_en_o;
  logic                  valid_o;
  logic                  ready_i;

  modport slave (
    input  data_i, valid_i, ready_i,
    output ready_o, addr_o, lu_data_o, lu_reset_o, add_bias_o, sum_en_o, valid_o
  );

  modport master (
    output data_i, valid_i, ready_i,
    input  ready_o, addr_o, lu_data_o, lu_reset_o, add_bias_o, sum_en_o, valid_o
  );
endinterface

// File: rtl/lu_sequencer.sv
// Control sequencer for one logical_unit neuron: clears the accumulator,
// loads the bias, streams INPUT_SIZE weighted inputs, waits out the LU
// pipeline and then holds the result until the consumer takes it.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_CLEAR | one cycle, lu_reset_o high, accumulator cleared
// S_BIAS  | one cycle, bias word (addr 0) added via add_bias/sum_en
// S_ACCUM | accepting inputs, addr = k+1, sum_en follows valid_i
// S_WAIT  | LU_LATENCY cycles for the LU output pipeline to settle
// S_DONE  | valid_o high, LU untouched until ready_i
module lu_sequencer #(
  parameter int WORD_SIZE  = 16,
  parameter int INPUT_SIZE = 8,
  parameter int LU_LATENCY = 0,
  parameter int ADDR_WIDTH = $clog2(INPUT_SIZE + 1)
) (
  input  logic           clk_i,
  input  logic           reset_n_i,
  lu_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_CLEAR,
    S_BIAS,
    S_ACCUM,
    S_WAIT,
    S_DONE
  } state_t;

  localparam int WAIT_W = (LU_LATENCY > 0) ? $clog2(LU_LATENCY + 1) : 1;
  localparam logic [ADDR_WIDTH-1:0] K_LAST = ADDR_WIDTH'(INPUT_SIZE - 1);
  // Down-counter load value: terminal count 0 is reached after LU_LATENCY cycles.
  localparam logic [WAIT_W-1:0] WAIT_LOAD = (LU_LATENCY > 0) ? WAIT_W'(LU_LATENCY - 1) : '0;

  state_t                state;
  logic [ADDR_WIDTH-1:0] k;
  logic [WAIT_W-1:0]     wait_cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  ready_q;
  logic                  valid_q;
  logic                  bias_q;
  logic                  lu_reset_q;
  logic [WORD_SIZE-1:0]  fwd_data;

  // Sequencer state, input counter, latency timer and registered controls.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state      <= S_CLEAR;
      k          <= '0;
      wait_cnt   <= '0;
      addr_q     <= '0;
      ready_q    <= 1'b0;
      valid_q    <= 1'b0;
      bias_q     <= 1'b0;
      lu_reset_q <= 1'b1;
    end else begin
      case (state)
        S_CLEAR: begin
          lu_reset_q <= 1'b0;
          bias_q     <= 1'b1;
          addr_q     <= '0;
          state      <= S_BIAS;
        end
        S_BIAS: begin
          bias_q  <= 1'b0;
          ready_q <= 1'b1;
          addr_q  <= ADDR_WIDTH'(1);
          state   <= S_ACCUM;
        end
        S_ACCUM: begin
          if (bus.valid_i && ready_q) begin
            if (k == K_LAST) begin
              k       <= '0;
              ready_q <= 1'b0;
              addr_q  <= '0;
              if (LU_LATENCY == 0) begin
                valid_q <= 1'b1;
                state   <= S_DONE;
              end else begin
                wait_cnt <= WAIT_LOAD;
                state    <= S_WAIT;
              end
            end else begin
              k      <= k + ADDR_WIDTH'(1);
              addr_q <= k + ADDR_WIDTH'(2);
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == '0) begin
            valid_q <= 1'b1;
            state   <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end
        end
        S_DONE: begin
          if (bus.ready_i) begin
            valid_q    <= 1'b0;
            lu_reset_q <= 1'b1;
            state      <= S_CLEAR;
          end
        end
        default: begin
          state      <= S_CLEAR;
          k          <= '0;
          wait_cnt   <= '0;
          addr_q     <= '0;
          ready_q    <= 1'b0;
          valid_q    <= 1'b0;
          bias_q     <= 1'b0;
          lu_reset_q <= 1'b1;
        end
      endcase
    end
  end

  // sum_en must follow valid_i in the same cycle during ACCUM, so it is the
  // only control that is not purely registered.
  assign fwd_data       = bus.data_i;
  assign bus.lu_data_o  = fwd_data;
  assign bus.ready_o    = ready_q;
  assign bus.addr_o     = addr_q;
  assign bus.lu_reset_o = lu_reset_q;
  assign bus.add_bias_o = bias_q;
  assign bus.sum_en_o   = bias_q | (ready_q & bus.valid_i);
  assign bus.valid_o    = valid_q;

endmodule
